// File: rtl/shake256_stream_ctrl.sv
// rtl/shake256_stream_ctrl.sv - SHAKE256 sequencer: word-stream packing, rate-block absorb, squeeze unload
module shake256_stream_ctrl #(
  parameter int MAX_BLOCKS = 4,
  parameter int OUT_BLOCKS = 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [63:0]   in_data,
  input  logic          in_last,
  input  logic [6:0]    in_bits,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [63:0]   out_data,
  output logic          out_last,
  output logic          err_overflow,
  output logic          err_overrun,
  output logic          core_reset,
  output logic [1087:0] core_message,
  output logic [10:0]   core_length,
  input  logic          core_busy,
  input  logic          core_full,
  input  logic          core_squeezed,
  input  logic [1087:0] core_hash
);

  localparam int NW = 17 * MAX_BLOCKS;
  localparam int CW = $clog2(NW + 1);
  localparam int TW = $clog2(64 * NW + 1);
  localparam int BW = $clog2(MAX_BLOCKS + 1);

  typedef enum logic [1:0] {LOAD, ABSORB, SQUEEZE, DRAIN} state_t;

  state_t          state, state_n;
  logic [63:0]     buffer [NW];
  logic [CW-1:0]   count;
  logic            dropping;
  logic [TW-1:0]   rem;
  logic [BW-1:0]   blk;
  logic            sq_q, sq_q2;
  logic [1087:0]   hash_q;
  logic [4:0]      word_idx;
  logic [3:0]      out_blk;
  logic            unused_busy;

  logic            accept, overflow_word, last_block, consume, sq_rise;
  logic            out_fire, final_blk;
  logic [6:0]      nb;
  logic [63:0]     wmask;
  logic [CW-1:0]   base;

  assign unused_busy   = core_busy;
  assign accept        = in_valid & in_ready;
  assign overflow_word = dropping | (count == CW'(NW));
  assign last_block    = rem <= TW'(1088);
  assign consume       = (state == ABSORB) & ~core_full;
  assign sq_rise       = sq_q & ~sq_q2;
  assign out_fire      = out_valid & out_ready;
  assign final_blk     = out_blk == 4'(OUT_BLOCKS - 1);
  assign nb            = (in_bits > 7'd64) ? 7'd64 : in_bits;
  // Keep only the nb most significant bits of the closing word.
  assign wmask         = in_last ? ~(64'hFFFF_FFFF_FFFF_FFFF >> nb) : 64'hFFFF_FFFF_FFFF_FFFF;
  assign base          = CW'(blk) * CW'(17);
  assign out_data      = hash_q[1087:1024];
  assign out_last      = (state == DRAIN) & (word_idx == 5'd16) & final_blk;

  always_ff @(posedge clock) begin
    if (!reset) state <= LOAD;
    else        state <= state_n;
  end

  always_comb begin
    state_n    = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    core_reset = 1'b0;
    case (state)
      LOAD: begin
        in_ready = 1'b1;
        if (accept && in_last && !overflow_word) state_n = ABSORB;
      end
      ABSORB: begin
        core_reset = 1'b1;
        if (consume && last_block) state_n = SQUEEZE;
      end
      SQUEEZE: begin
        core_reset = 1'b1;
        if (sq_rise) state_n = DRAIN;
      end
      DRAIN: begin
        core_reset = 1'b1;
        out_valid  = 1'b1;
        if (out_fire && word_idx == 5'd16) state_n = final_blk ? LOAD : SQUEEZE;
      end
      default: state_n = LOAD;
    endcase
  end

  always_comb begin
    core_message = '0;
    core_length  = '0;
    if (state == ABSORB) begin
      core_length = last_block ? 11'(rem) : 11'd1089;
      for (int i = 0; i < 17; i++) core_message[1087-64*i -: 64] = buffer[base + CW'(i)];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < NW; i++) buffer[i] <= '0;
      count        <= '0;
      dropping     <= 1'b0;
      rem          <= '0;
      blk          <= '0;
      sq_q         <= 1'b0;
      sq_q2        <= 1'b0;
      hash_q       <= '0;
      word_idx     <= '0;
      out_blk      <= '0;
      err_overflow <= 1'b0;
      err_overrun  <= 1'b0;
    end else begin
      err_overflow <= 1'b0;
      sq_q         <= core_squeezed;
      sq_q2        <= sq_q;
      case (state)
        LOAD: begin
          if (accept) begin
            if (overflow_word) begin
              // Oversized message: swallow words until its last one, then start clean.
              if (in_last) begin
                err_overflow <= 1'b1;
                dropping     <= 1'b0;
                count        <= '0;
                for (int i = 0; i < NW; i++) buffer[i] <= '0;
              end else begin
                dropping <= 1'b1;
              end
            end else begin
              buffer[count] <= in_data & wmask;
              count         <= count + 1'b1;
              if (in_last) begin
                rem <= TW'({count, 6'b0}) + TW'(nb);
                blk <= '0;
              end
            end
          end
        end
        ABSORB: begin
          if (consume) begin
            blk <= blk + 1'b1;
            rem <= rem - TW'(1088);
          end
        end
        SQUEEZE: begin
          if (sq_rise) begin
            hash_q   <= core_hash;
            word_idx <= '0;
          end
        end
        DRAIN: begin
          if (sq_rise) err_overrun <= 1'b1;
          if (out_fire) begin
            hash_q   <= hash_q << 64;
            word_idx <= word_idx + 1'b1;
            if (word_idx == 5'd16) begin
              word_idx <= '0;
              if (final_blk) begin
                out_blk <= '0;
                count   <= '0;
                for (int i = 0; i < NW; i++) buffer[i] <= '0;
              end else begin
                out_blk <= out_blk + 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shake256_stream_ctrl.sv
// tb/tb_shake256_stream_ctrl.sv - directed scoreboard bench for shake256_stream_ctrl with a stub core
module tb_shake256_stream_ctrl;

  localparam int MAXB = 4;
  localparam int OUTB = 2;
  localparam int NW   = 17 * MAXB;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0, in_ready, in_last = 1'b0;
  logic [63:0]   in_data = '0;
  logic [6:0]    in_bits = '0;
  logic          out_valid, out_ready = 1'b0, out_last;
  logic [63:0]   out_data;
  logic          err_overflow, err_overrun, core_reset;
  logic [1087:0] core_message;
  logic [10:0]   core_length;
  logic          core_busy = 1'b0, core_full = 1'b0, core_squeezed = 1'b0;
  logic [1087:0] core_hash = '0;

  shake256_stream_ctrl #(.MAX_BLOCKS(MAXB), .OUT_BLOCKS(OUTB)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last), .in_bits(in_bits),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .err_overflow(err_overflow), .err_overrun(err_overrun),
    .core_reset(core_reset), .core_message(core_message), .core_length(core_length),
    .core_busy(core_busy), .core_full(core_full), .core_squeezed(core_squeezed), .core_hash(core_hash)
  );

  always #5 clock = ~clock;

  int passed = 0;
  int total  = 0;
  logic [63:0]   mbuf [NW];
  int            exp_len_q [$];
  logic [1087:0] exp_msg_q [$];
  logic [64:0]   exp_out_q [$];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk1(input string tag, input logic got, input logic exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s got=%b exp=%b", tag, got, exp);
  endtask

  task automatic chk64(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic chkw(input string tag, input logic [1087:0] got, input logic [1087:0] exp);
    int k;
    k = 0;
    for (int i = 16; i >= 0; i--) if (got[1087-64*i -: 64] !== exp[1087-64*i -: 64]) k = i;
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s word%0d got=%0h exp=%0h", tag, k, got[1087-64*k -: 64], exp[1087-64*k -: 64]);
  endtask

  function automatic logic [63:0] mask_model(input logic [63:0] d, input int bits);
    logic [63:0] r;
    r = d;
    for (int i = 0; i < 64; i++) if (i >= bits) r[63-i] = 1'b0;
    return r;
  endfunction

  // kind: 0 random words, 1 repeated 0xA3, 2 leading 5'b10011 then random
  task automatic send_msg(input int nw, input int bits, input int kind);
    logic [63:0] d;
    for (int i = 0; i < NW; i++) mbuf[i] = '0;
    for (int w = 0; w < nw; w++) begin
      if (kind == 1)      d = {8{8'hA3}};
      else if (kind == 2) d = {5'b10011, 27'($urandom), $urandom};
      else                d = {$urandom, $urandom};
      in_valid = 1'b1;
      in_data  = d;
      in_last  = (w == nw - 1);
      in_bits  = 7'(bits);
      if (w == nw - 1) d = mask_model(d, bits);
      if (w < NW) mbuf[w] = d;
      chk1("in_ready_load", in_ready, 1'b1);
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic push_blocks(input int nw, input int bits);
    int tb_bits, nblk;
    logic [1087:0] m;
    tb_bits = 64 * (nw - 1) + bits;
    nblk = (tb_bits == 0) ? 1 : (tb_bits + 1087) / 1088;
    for (int b = 0; b < nblk; b++) begin
      for (int i = 0; i < 17; i++) m[1087-64*i -: 64] = mbuf[17*b + i];
      exp_msg_q.push_back(m);
      exp_len_q.push_back((b < nblk - 1) ? 1089 : tb_bits - 1088 * (nblk - 1));
    end
  endtask

  task automatic absorb(input int hold_blk);
    int b;
    b = 0;
    chk1("core_reset_absorb", core_reset, 1'b1);
    chk1("in_ready_absorb", in_ready, 1'b0);
    while (exp_len_q.size() > 0) begin
      if (b == hold_blk) begin
        core_full = 1'b1;
        for (int h = 0; h < 3; h++) begin
          chk64("len_held", 64'(core_length), 64'(exp_len_q[0]));
          chkw("msg_held", core_message, exp_msg_q[0]);
          tick();
        end
        core_full = 1'b0;
      end
      chk64("core_length", 64'(core_length), 64'(exp_len_q.pop_front()));
      chkw("core_message", core_message, exp_msg_q.pop_front());
      tick();
      b++;
    end
    chk64("len_after_absorb", 64'(core_length), 64'd0);
    chk1("out_valid_squeeze", out_valid, 1'b0);
  endtask

  task automatic squeeze_block(input bit overrun, input bit final_b);
    logic [1087:0] h;
    logic [63:0]   prev;
    logic [64:0]   e;
    int n;
    for (int i = 0; i < 34; i++) h[32*i +: 32] = $urandom;
    for (int w = 0; w < 17; w++) exp_out_q.push_back({final_b && (w == 16), h[1087-64*w -: 64]});
    core_hash     = h;
    core_squeezed = 1'b1;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    chk64("squeeze_latency", 64'(n), 64'd2);
    core_squeezed = 1'b0;
    for (int w = 0; w < 17; w++) begin
      if (w == 6 && overrun) core_squeezed = 1'b1;
      if (w == 9 && overrun) core_squeezed = 1'b0;
      if (w % 4 == 1) begin
        out_ready = 1'b0;
        prev = out_data;
        tick();
        chk64("out_data_stall", out_data, prev);
        chk1("out_valid_stall", out_valid, 1'b1);
      end
      out_ready = 1'b1;
      e = exp_out_q.pop_front();
      chk64("out_data", out_data, e[63:0]);
      chk1("out_last", out_last, e[64]);
      tick();
    end
    out_ready = 1'b0;
  endtask

  task automatic run_msg(input int nw, input int bits, input int kind, input int hold_blk, input bit overrun);
    send_msg(nw, bits, kind);
    push_blocks(nw, bits);
    absorb(hold_blk);
    squeeze_block(overrun, 1'b0);
    squeeze_block(1'b0, 1'b1);
    chk1("core_reset_rearm", core_reset, 1'b0);
    chk1("in_ready_rearm", in_ready, 1'b1);
    chk1("out_valid_rearm", out_valid, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    tick();
    tick();
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_out_last", out_last, 1'b0);
    chk1("rst_err_overflow", err_overflow, 1'b0);
    chk1("rst_err_overrun", err_overrun, 1'b0);
    chk1("rst_core_reset", core_reset, 1'b0);
    chk64("rst_core_length", 64'(core_length), 64'd0);
    chkw("rst_core_message", core_message, '0);
    chk1("rst_in_ready", in_ready, 1'b1);
    reset = 1'b1;
    tick();

    run_msg(1, 0, 0, -1, 1'b0);
    run_msg(1, 5, 2, -1, 1'b0);
    run_msg(6, 24, 0, -1, 1'b0);
    run_msg(25, 64, 1, 0, 1'b0);

    send_msg(69, 64, 0);
    chk1("overflow_pulse", err_overflow, 1'b1);
    chk1("overflow_core_reset", core_reset, 1'b0);
    tick();
    chk1("overflow_pulse_end", err_overflow, 1'b0);
    chk1("overflow_in_ready", in_ready, 1'b1);
    chk1("overflow_core_reset2", core_reset, 1'b0);

    run_msg(68, 64, 0, 2, 1'b0);
    run_msg(3, 17, 0, -1, 1'b1);
    chk1("err_overrun_sticky", err_overrun, 1'b1);

    send_msg(30, 64, 0);
    core_full = 1'b1;
    tick();
    chk1("mid_absorb_core_reset", core_reset, 1'b1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    core_full = 1'b0;
    chk1("abort_core_reset", core_reset, 1'b0);
    chk1("abort_in_ready", in_ready, 1'b1);
    chk1("abort_err_overrun", err_overrun, 1'b0);
    chk64("abort_core_length", 64'(core_length), 64'd0);

    run_msg(2, 40, 0, -1, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
